pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock supervisor for the 50 MHz → 100 MHz PLL stage. Runs on the free-running 50 MHz board reference clock and drives the PLL's `rst`. It monitors the PLL's asynchronous `locked` output, re-resets the PLL if lock is not acquired in time, and releases the system reset only after lock has been stable for a programmable interval. Downstream logic in the 100 MHz domain uses `sys_rst` as an asynchronous-assert reset and synchronises its deassertion locally.

## Interface
Parameters:
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before retrying (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before release.
- `CNT_W`, 16: width of the shared cycle counter; must hold the largest of the three parameters.

Ports:
- `refclk`  in  1  free-running 50 MHz reference clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `locked`  in  1  PLL lock indication, asynchronous to refclk.
- `pll_rst`  out  1  reset to the PLL, active-high.
- `sys_rst`  out  1  system reset, active-high.
- `ready`  out  1  high while in RUN; equals `~sys_rst`.
- `relock_count`  out  8  number of PLL reset pulses issued after the first; saturates at 255.
- `lock_lost`  out  1  sticky; set on loss of lock while in RUN, cleared only by `rst`.
- `state`  out  2  current state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.

## Operation
- `locked` passes through a 2-flop synchroniser (`lock_s`) that resets to 0. All decisions use `lock_s`.
- A single counter `cnt` (CNT_W bits) is cleared on every state transition. Otherwise it increments each cycle.
- PLL_RST:
  - `pll_rst`=1, `sys_rst`=1.
  - When `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0, `sys_rst`=1.
  - If `lock_s`=1, go to STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT-1, go to PLL_RST and increment `relock_count` (saturating).
  - If `lock_s` rises on the timeout cycle, lock wins: go to STABLE.
- STABLE:
  - `pll_rst`=0, `sys_rst`=1.
  - If `lock_s`=0, go to WAIT_LOCK. `cnt` clears, so the timeout restarts.
  - When `cnt`==STABLE_CYCLES-1 and `lock_s`=1, go to RUN.
- RUN:
  - `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - If `lock_s`=0: go to PLL_RST, set `lock_lost`, and increment `relock_count`.
  - `cnt` is held at 0 in RUN.
- All outputs are registered, with no combinational path from `locked` to any output.
- Reset values:
  - `state`=PLL_RST, `cnt`=0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - `relock_count`=0, `lock_lost`=0, `lock_s`=0.
- Asserting `rst` at any time, including mid-sequence or in RUN, immediately forces these values.

## Timing
- Reset release: `rst` falls before refclk edge 0. `pll_rst` stays high through edge RST_CYCLES-1 and is low after edge RST_CYCLES-1 (RST_CYCLES cycles of PLL reset).
- Lock synchroniser: `locked` rising meets setup at edge k. `lock_s`=1 after edge k+1, and the state is STABLE after edge k+2.
- Release: the state enters STABLE at edge s. `sys_rst` falls and `ready` rises after edge s+STABLE_CYCLES. Total worst-case latency from `locked` to `sys_rst` low is STABLE_CYCLES+2 cycles.
- Lock loss in RUN: `locked` falls at edge k. After edge k+2, `sys_rst`=1, `pll_rst`=1 and `lock_lost`=1 together.
- A glitch on `locked` in STABLE restarts the full STABLE_CYCLES wait via WAIT_LOCK.
- Retry period while lock never arrives: RST_CYCLES+LOCK_TIMEOUT cycles per `pll_rst` pulse.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
1. Clean start.
   - Stimulus: release `rst`, then raise `locked` 10 cycles later.
   - Response: `pll_rst` high for exactly 4 cycles. `sys_rst` falls 8+2 cycles after `locked` rises. `relock_count`=0, `lock_lost`=0, `state`=3.
2. Lock timeout.
   - Stimulus: hold `locked`=0 for 60 cycles.
   - Response: `pll_rst` pulses of 4 cycles every 24 cycles. `relock_count` increments 0→1→2. `sys_rst` stays 1.
3. Glitch in STABLE.
   - Stimulus: `locked` drops for 1 cycle 5 cycles into STABLE.
   - Response: state goes to WAIT_LOCK and back. `sys_rst` falls 8 cycles after STABLE is re-entered, not earlier. `relock_count` unchanged.
4. Loss in RUN.
   - Stimulus: drop `locked` while `ready`=1.
   - Response: 2 cycles later `sys_rst`=1, `pll_rst`=1, `lock_lost`=1, `relock_count`+1. After relock, `lock_lost` remains 1.
5. Reset mid-sequence.
   - Stimulus: assert `rst` asynchronously, between clock edges, during STABLE and again during RUN.
   - Response: outputs take reset values immediately, without waiting for an edge, including `lock_lost`=0 and `relock_count`=0.
6. Saturation.
   - Stimulus: hold `locked` low for more than 256 retry periods.
   - Response: `relock_count` stops at 255.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the PLL: pulses the PLL reset, retries on lock timeout,
// and releases the system reset only after lock has been stable for STABLE_CYCLES.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       lock_lost,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             lost_q, lost_d;
    logic             lock_meta_q, lock_s_q;
    logic             pll_rst_q, sys_rst_q, ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        relock_d = relock_q;
        lost_d   = lost_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s_q) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            STABLE: begin
                if (!lock_s_q)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = PLL_RST;
                    lost_d  = 1'b1;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            relock_q    <= 8'd0;
            lost_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            relock_q    <= relock_d;
            lost_q      <= lost_d;
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_rst_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign lock_lost    = lost_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; expected
// values are hand-computed edge numbers counted from each reset release.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;
    logic       lock_lost;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = -1;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .CNT_W        (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .relock_count(relock_count),
        .lock_lost   (lock_lost),
        .state       (state)
    );

    // clock / reset
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // checking
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"},   32'(state), 32'd0);
        check_eq({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check_eq({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check_eq({tag, "_ready"},   32'(ready), 32'd0);
        check_eq({tag, "_relock"},  32'(relock_count), 32'd0);
        check_eq({tag, "_lost"},    32'(lock_lost), 32'd0);
    endtask

    // drivers
    task automatic tick();
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int t);
        while (edge_n < t) tick();
    endtask

    task automatic release_rst();
        @(negedge refclk);
        rst    = 1'b0;
        edge_n = -1;
    endtask

    task automatic assert_rst_async();
        @(negedge refclk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) tick();
        check_reset_values("por");

        // Clean start: lock arrives well before the timeout
        release_rst();
        goto_edge(2);  check_eq("t1_pll_rst_hold", 32'(pll_rst), 32'd1);
        goto_edge(3);  check_eq("t1_pll_rst_low",  32'(pll_rst), 32'd0);
                       check_eq("t1_wait_lock",    32'(state), 32'd1);
        goto_edge(9);  locked = 1'b1;
        goto_edge(11); check_eq("t1_sync_delay",   32'(state), 32'd1);
        goto_edge(12); check_eq("t1_stable",       32'(state), 32'd2);
        goto_edge(19); check_eq("t1_sys_rst_held", 32'(sys_rst), 32'd1);
        goto_edge(20); check_eq("t1_sys_rst_rel",  32'(sys_rst), 32'd0);
                       check_eq("t1_ready",        32'(ready), 32'd1);
                       check_eq("t1_state_run",    32'(state), 32'd3);
                       check_eq("t1_relock",       32'(relock_count), 32'd0);
                       check_eq("t1_lost",         32'(lock_lost), 32'd0);

        // Lock loss in RUN, then relock
        goto_edge(22); locked = 1'b0;
        goto_edge(24); check_eq("t4_still_run",    32'(sys_rst), 32'd0);
        goto_edge(25); check_eq("t4_sys_rst",      32'(sys_rst), 32'd1);
                       check_eq("t4_pll_rst",      32'(pll_rst), 32'd1);
                       check_eq("t4_lost",         32'(lock_lost), 32'd1);
                       check_eq("t4_relock",       32'(relock_count), 32'd1);
                       check_eq("t4_ready",        32'(ready), 32'd0);
                       locked = 1'b1;
        goto_edge(29); check_eq("t4_wait_lock",    32'(state), 32'd1);
        goto_edge(37); check_eq("t4_relock_hold",  32'(sys_rst), 32'd1);
        goto_edge(38); check_eq("t4_rerun",        32'(state), 32'd3);
                       check_eq("t4_lost_sticky",  32'(lock_lost), 32'd1);
                       check_eq("t4_relock_keep",  32'(relock_count), 32'd1);

        // Asynchronous reset while in RUN
        assert_rst_async();
        check_reset_values("t5_run");

        // Glitch on locked during STABLE restarts the wait
        release_rst();
        goto_edge(3);  check_eq("t3_wait_lock",    32'(state), 32'd1);
        goto_edge(4);  check_eq("t3_stable",       32'(state), 32'd2);
        goto_edge(8);  locked = 1'b0;
        goto_edge(9);  locked = 1'b1;
                       check_eq("t3_pre_glitch",   32'(state), 32'd2);
        goto_edge(10); check_eq("t3_sync_lag",     32'(state), 32'd2);
        goto_edge(11); check_eq("t3_back_wait",    32'(state), 32'd1);
        goto_edge(12); check_eq("t3_restable",     32'(state), 32'd2);
                       check_eq("t3_no_early_rel", 32'(sys_rst), 32'd1);
        goto_edge(19); check_eq("t3_sys_rst_held", 32'(sys_rst), 32'd1);
        goto_edge(20); check_eq("t3_sys_rst_rel",  32'(sys_rst), 32'd0);
                       check_eq("t3_relock",       32'(relock_count), 32'd0);

        // Asynchronous reset while in STABLE after a lock loss
        goto_edge(22); locked = 1'b0;
        goto_edge(25); check_eq("t5_pre_lost",     32'(lock_lost), 32'd1);
                       check_eq("t5_pre_relock",   32'(relock_count), 32'd1);
                       locked = 1'b1;
        goto_edge(32); check_eq("t5_in_stable",    32'(state), 32'd2);
        locked = 1'b0;
        assert_rst_async();
        check_reset_values("t5_stable");

        // Lock never arrives: retry cadence, then counter saturation
        release_rst();
        goto_edge(2);    check_eq("t2_pll_rst_hold", 32'(pll_rst), 32'd1);
        goto_edge(3);    check_eq("t2_pll_rst_low",  32'(pll_rst), 32'd0);
        goto_edge(10);   check_eq("t2_sys_rst_a",    32'(sys_rst), 32'd1);
        goto_edge(22);   check_eq("t2_pre_timeout",  32'(state), 32'd1);
                         check_eq("t2_relock_0",     32'(relock_count), 32'd0);
        goto_edge(23);   check_eq("t2_timeout",      32'(pll_rst), 32'd1);
                         check_eq("t2_relock_1",     32'(relock_count), 32'd1);
        goto_edge(26);   check_eq("t2_pulse_hold",   32'(pll_rst), 32'd1);
        goto_edge(27);   check_eq("t2_pulse_end",    32'(pll_rst), 32'd0);
        goto_edge(40);   check_eq("t2_sys_rst_b",    32'(sys_rst), 32'd1);
        goto_edge(46);   check_eq("t2_relock_1b",    32'(relock_count), 32'd1);
        goto_edge(47);   check_eq("t2_relock_2",     32'(relock_count), 32'd2);
                         check_eq("t2_pulse2",       32'(pll_rst), 32'd1);
        goto_edge(59);   check_eq("t2_sys_rst_c",    32'(sys_rst), 32'd1);
        goto_edge(6095); check_eq("t6_relock_254",   32'(relock_count), 32'd254);
        goto_edge(6118); check_eq("t6_relock_254b",  32'(relock_count), 32'd254);
        goto_edge(6119); check_eq("t6_relock_255",   32'(relock_count), 32'd255);
        goto_edge(6143); check_eq("t6_sat_pulse",    32'(pll_rst), 32'd1);
                         check_eq("t6_sat_hold",     32'(relock_count), 32'd255);
        goto_edge(6200); check_eq("t6_sat_final",    32'(relock_count), 32'd255);
                         check_eq("t6_lost",         32'(lock_lost), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
